// File: rtl/seg_scan4_pkg.sv
// Shared definitions for the multiplexed 7-segment display blocks:
// digit count, anode-off pattern, nibble select and leading-zero blanking.
package seg_pkg;

   localparam int              NDIG   = 4;
   localparam logic [NDIG-1:0] AN_OFF = 4'b1111;

   typedef logic [1:0] idx_t;

   function automatic logic [3:0] nib_sel(input logic [15:0] d, input idx_t i);
      return d[{i, 2'b00} +: 4];
   endfunction

   // Bit i set when digit i is a leading zero; digit 0 always stays lit
   function automatic logic [3:0] lz_mask(input logic [15:0] d);
      logic [3:0] m;
      m[3] = (d[15:12] == 4'h0);
      m[2] = m[3] & (d[11:8] == 4'h0);
      m[1] = m[2] & (d[7:4] == 4'h0);
      m[0] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/seg_scan4_if.sv
// Host-side load port and display-side drive signals of the 4-digit scanner.
interface seg_scan4_if;

   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [3:0]  x;
   logic [3:0]  an;
   logic        dp;
   logic        pending;

   modport master (output load, value, dp_in, blank_lz,
                   input  x, an, dp, pending);
   modport slave  (input  load, value, dp_in, blank_lz,
                   output x, an, dp, pending);

endinterface

// File: rtl/seg_scan4_prescaler.sv
// Dwell prescaler: counts 0..DIV-1 and flags the wrap cycle.
module seg_prescaler #(
   parameter int DIV   = 50000,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] cnt,
   output logic             tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/seg_scan4.sv
// 4-digit common-anode scanner: frame-synchronous value updates, optional
// leading-zero blanking and an all-anodes-off guard at the start of each dwell.
module seg_scan4
   import seg_pkg::*;
#(
   parameter int DIV   = 50000,
   parameter int GUARD = 16,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   seg_scan4_if.slave  bus
);

   localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

   logic [CNT_W-1:0] cnt;
   logic             tick, frame;

   idx_t        idx_q,       idx_d;
   logic [15:0] disp_q,      disp_d;
   logic [3:0]  disp_dp_q,   disp_dp_d;
   logic [15:0] shadow_q,    shadow_d;
   logic [3:0]  shadow_dp_q, shadow_dp_d;
   logic        pending_q,   pending_d;
   logic        blank_q,     blank_d;

   logic [3:0]  lz;
   logic        lit;

   seg_prescaler #(.DIV(DIV), .CNT_W(CNT_W)) u_pre (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (cnt),
      .tick  (tick)
   );

   assign frame = tick & (idx_q == 2'd3);

   always_comb begin
      idx_d       = tick ? idx_q + 2'd1 : idx_q;
      disp_d      = disp_q;
      disp_dp_d   = disp_dp_q;
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      pending_d   = pending_q;
      blank_d     = bus.blank_lz;
      // A load on the boundary edge beats any older shadow
      if (frame && bus.load) begin
         disp_d      = bus.value;
         disp_dp_d   = bus.dp_in;
         shadow_d    = bus.value;
         shadow_dp_d = bus.dp_in;
         pending_d   = 1'b0;
      end else if (frame && pending_q) begin
         disp_d      = shadow_q;
         disp_dp_d   = shadow_dp_q;
         pending_d   = 1'b0;
      end else if (bus.load) begin
         shadow_d    = bus.value;
         shadow_dp_d = bus.dp_in;
         pending_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         disp_q      <= '0;
         disp_dp_q   <= '0;
         shadow_q    <= '0;
         shadow_dp_q <= '0;
         pending_q   <= 1'b0;
         blank_q     <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         disp_q      <= disp_d;
         disp_dp_q   <= disp_dp_d;
         shadow_q    <= shadow_d;
         shadow_dp_q <= shadow_dp_d;
         pending_q   <= pending_d;
         blank_q     <= blank_d;
      end
   end

   // Outputs depend on registers only, so nothing from the inputs glitches the display
   always_comb begin
      lz          = blank_q ? lz_mask(disp_q) : 4'b0000;
      lit         = (cnt >= GUARD_C) && !lz[idx_q];
      bus.x       = nib_sel(disp_q, idx_q);
      bus.an      = lit ? ~(4'b0001 << idx_q) : AN_OFF;
      bus.dp      = lit ? ~disp_dp_q[idx_q] : 1'b1;
      bus.pending = pending_q;
   end

endmodule

// File: tb/tb_seg_scan4.sv
// Self-checking bench for seg_scan4 with DIV=8, GUARD=2: per-dwell scoreboard
// of expected digit/anode/dp, plus handshake and reset checks.
module tb_seg_scan4;

   localparam int DIV   = 8;
   localparam int GUARD = 2;
   localparam int CNT_W = 16;
   localparam int FRAME = 4 * DIV;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] an;
      logic       dp;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg_scan4_if bus ();

   seg_scan4 #(.DIV(DIV), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t exp_q[$];
   int   n;
   int   n_cmp;
   int   n_bad;

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic goto_ph(input int ph);
      while ((n % FRAME) != ph) step();
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
      bus.value = v;
      bus.dp_in = d;
      bus.load  = 1'b1;
      step();
      bus.load  = 1'b0;
   endtask

   task automatic push_dig(input logic [3:0] x, input logic [3:0] an, input logic dp);
      exp_t e;
      e.x  = x;
      e.an = an;
      e.dp = dp;
      exp_q.push_back(e);
   endtask

   // Consume four scoreboard entries over one frame: guard cycle then lit part
   task automatic run_frame(input string tag);
      exp_t e;
      goto_ph(0);
      for (int i = 0; i < 4; i++) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s dig%0d: scoreboard empty", tag, i);
            e = '0;
         end else begin
            e = exp_q.pop_front();
         end
         n_cmp++;
         if (bus.an !== 4'b1111 || bus.x !== e.x || bus.dp !== 1'b1) begin
            n_bad++;
            $display("FAIL %s dig%0d guard: got x=%h an=%b dp=%b, want x=%h an=1111 dp=1",
                     tag, i, bus.x, bus.an, bus.dp, e.x);
         end
         while ((n % DIV) != GUARD) step();
         n_cmp++;
         if ({bus.x, bus.an, bus.dp} !== e) begin
            n_bad++;
            $display("FAIL %s dig%0d lit: got x=%h an=%b dp=%b, want x=%h an=%b dp=%b",
                     tag, i, bus.x, bus.an, bus.dp, e.x, e.an, e.dp);
         end
         while ((n % DIV) != 0) step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      n_cmp++;
      if (bus.an !== 4'b1111 || bus.x !== 4'h0 || bus.dp !== 1'b1 || bus.pending !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_hold: got x=%h an=%b dp=%b pend=%b, want 0/1111/1/0",
                  bus.x, bus.an, bus.dp, bus.pending);
      end
      rst_n = 1'b1;
      n = 0;
      for (int c = 0; c <= 10; c++) begin
         logic [3:0] want;
         want = (c < 2) ? 4'b1111 : (c < 8) ? 4'b1110 : (c < 10) ? 4'b1111 : 4'b1101;
         n_cmp++;
         if (bus.an !== want) begin
            n_bad++;
            $display("FAIL reset_dwell c=%0d: got an=%b, want an=%b", c, bus.an, want);
         end
         if (c < 10) step();
      end
   endtask

   task automatic test_load();
      goto_ph(10);
      pulse_load(16'h12AF, 4'b0100);
      n_cmp++;
      if (bus.pending !== 1'b1) begin
         n_bad++; $display("FAIL load_pending_set: got %b, want 1", bus.pending);
      end
      goto_ph(FRAME - 1);
      n_cmp++;
      if (bus.pending !== 1'b1) begin
         n_bad++; $display("FAIL load_pending_hold: got %b, want 1", bus.pending);
      end
      step();
      n_cmp++;
      if (bus.pending !== 1'b0) begin
         n_bad++; $display("FAIL load_pending_clr: got %b, want 0", bus.pending);
      end
      push_dig(4'hF, 4'b1110, 1'b1);
      push_dig(4'hA, 4'b1101, 1'b1);
      push_dig(4'h2, 4'b1011, 1'b0);
      push_dig(4'h1, 4'b0111, 1'b1);
      run_frame("load_12AF");
   endtask

   task automatic test_blank();
      bus.blank_lz = 1'b1;
      goto_ph(5);
      pulse_load(16'h0030, 4'b0000);
      push_dig(4'h0, 4'b1110, 1'b1);
      push_dig(4'h3, 4'b1101, 1'b1);
      push_dig(4'h0, 4'b1111, 1'b1);
      push_dig(4'h0, 4'b1111, 1'b1);
      run_frame("blank_0030");
      goto_ph(5);
      pulse_load(16'h0000, 4'b0000);
      push_dig(4'h0, 4'b1110, 1'b1);
      push_dig(4'h0, 4'b1111, 1'b1);
      push_dig(4'h0, 4'b1111, 1'b1);
      push_dig(4'h0, 4'b1111, 1'b1);
      run_frame("blank_0000");
      bus.blank_lz = 1'b0;
      push_dig(4'h0, 4'b1110, 1'b1);
      push_dig(4'h0, 4'b1101, 1'b1);
      push_dig(4'h0, 4'b1011, 1'b1);
      push_dig(4'h0, 4'b0111, 1'b1);
      run_frame("noblank_0000");
   endtask

   task automatic test_last_wins();
      goto_ph(5);
      pulse_load(16'h1111, 4'b0000);
      goto_ph(12);
      pulse_load(16'h2222, 4'b0000);
      n_cmp++;
      if (bus.pending !== 1'b1) begin
         n_bad++; $display("FAIL last_wins_pending: got %b, want 1", bus.pending);
      end
      push_dig(4'h2, 4'b1110, 1'b1);
      push_dig(4'h2, 4'b1101, 1'b1);
      push_dig(4'h2, 4'b1011, 1'b1);
      push_dig(4'h2, 4'b0111, 1'b1);
      run_frame("last_wins");
   endtask

   task automatic test_boundary_bypass();
      goto_ph(5);
      pulse_load(16'h1111, 4'b0000);
      goto_ph(FRAME - 1);
      n_cmp++;
      if (bus.pending !== 1'b1) begin
         n_bad++; $display("FAIL bypass_pre_pending: got %b, want 1", bus.pending);
      end
      pulse_load(16'hBEEF, 4'b0001);
      n_cmp++;
      if (bus.pending !== 1'b0) begin
         n_bad++; $display("FAIL bypass_pending: got %b, want 0", bus.pending);
      end
      for (int f = 0; f < 2; f++) begin
         push_dig(4'hF, 4'b1110, 1'b0);
         push_dig(4'hE, 4'b1101, 1'b1);
         push_dig(4'hE, 4'b1011, 1'b1);
         push_dig(4'hB, 4'b0111, 1'b1);
         run_frame("bypass_BEEF");
      end
   endtask

   task automatic test_mid_reset();
      goto_ph(3);
      pulse_load(16'h5A5A, 4'b1111);
      goto_ph(12);
      n_cmp++;
      if (bus.pending !== 1'b1 || bus.an !== 4'b1101 || bus.x !== 4'hE) begin
         n_bad++;
         $display("FAIL midrst_pre: got pend=%b an=%b x=%h, want 1/1101/E",
                  bus.pending, bus.an, bus.x);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.an !== 4'b1111 || bus.x !== 4'h0 || bus.dp !== 1'b1 || bus.pending !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_async: got x=%h an=%b dp=%b pend=%b, want 0/1111/1/0",
                  bus.x, bus.an, bus.dp, bus.pending);
      end
      step();
      step();
      rst_n = 1'b1;
      n = 0;
      for (int f = 0; f < 2; f++) begin
         push_dig(4'h0, 4'b1110, 1'b1);
         push_dig(4'h0, 4'b1101, 1'b1);
         push_dig(4'h0, 4'b1011, 1'b1);
         push_dig(4'h0, 4'b0111, 1'b1);
         run_frame("midrst_0000");
      end
      n_cmp++;
      if (bus.pending !== 1'b0) begin
         n_bad++; $display("FAIL midrst_pending: got %b, want 0", bus.pending);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n = 0; n_cmp = 0; n_bad = 0;
      bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
      test_reset();
      test_load();
      test_blank();
      test_last_wins();
      test_boundary_bypass();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
